spram_fifo_ctrl: RTL and testbench
==================================

Name: spram_fifo_ctrl

Overview:
- Circular-buffer FIFO controller placed directly upstream of the 64x16 single-port write-first RAM.
- Converts a valid/ready write stream and a valid/ready read stream into the RAM's single CLK/en/we/address/DI/DO port.
- Performs at most one RAM access per cycle. Read data is captured into an output register, because a later write-first access overwrites RAM DO.
- The RAM is instantiated beside this block, not inside it.

Parameters:
- DATA_W, 16, word width; matches RAM DI/DO.
- ADDR_W, 6, RAM address width.
- DEPTH, 64, capacity in words; must equal 2**ADDR_W.

Ports:
- CLK  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  synchronous reset, active-low.
- wr_valid  in  1  write request.
- wr_data  in  DATA_W  write word.
- wr_ready  out  1  write can be accepted this cycle.
- rd_valid  out  1  rd_data holds the head word.
- rd_data  out  DATA_W  head word.
- rd_ready  in  1  consumer pops the head when rd_valid=1.
- count  out  ADDR_W+1  total words held (0..DEPTH).
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- ram_en  out  1  RAM en.
- ram_we  out  1  RAM we.
- ram_addr  out  ADDR_W  RAM address.
- ram_di  out  DATA_W  RAM DI; always equals wr_data.
- ram_do  in  DATA_W  RAM DO; registered, valid the cycle after a read access.

Behaviour:
- Single clock CLK. Reset is synchronous and active-low on rst_n; no asynchronous reset anywhere.
- Reset state while rst_n=0 at a CLK edge:
  - wr_ptr=0, rd_ptr=0, mem_cnt=0, inflight=0, out_valid=0, out_data=0.
  - Outputs: rd_valid=0, rd_data=0, count=0, empty=1, full=0.
- Combinational gating during reset: while rst_n=0, wr_ready=0, ram_en=0 and ram_we=0. Reset mid-operation discards all stored and in-flight data; the RAM contents are left stale but unreachable.
- Internal state:
  - mem_cnt: words in RAM not yet read out.
  - inflight: a read was issued last cycle.
  - out_valid/out_data: the output register.
  - count = mem_cnt + inflight + out_valid; never exceeds DEPTH.
- pop = rd_valid & rd_ready.
- Read issue: rd_issue = (mem_cnt!=0) & !inflight & (!out_valid | rd_ready). Reads have priority over writes.
- Write issue:
  - wr_ready = !full & !rd_issue.
  - push = wr_valid & wr_ready.
  - There is no combinational path from wr_valid to wr_ready.
- RAM drive (combinational):
  - On rd_issue: en=1, we=0, addr=rd_ptr.
  - On push: en=1, we=1, addr=wr_ptr.
  - Otherwise: en=0, we=0, addr=0.
  - rd_issue and push are mutually exclusive by construction.
- Register updates per edge:
  - push: wr_ptr+1 (modulo DEPTH, natural wrap 63->0).
  - rd_issue: rd_ptr+1 (modulo DEPTH).
  - mem_cnt += push - rd_issue.
  - inflight <= rd_issue.
  - If inflight: out_data <= ram_do and out_valid <= 1.
  - Else if pop: out_valid <= 0, and out_data holds its value.
- Outputs: rd_valid = out_valid and rd_data = out_data, both registered.
- full and empty are combinational from count.
- Latency: a word accepted at edge k into an empty FIFO sets rd_valid after edge k+2.
- Throughput:
  - Writes: 1 per cycle while no read is needed.
  - Reads: 1 pop per 2 cycles sustained, because only one read may be in flight.
- Boundary rules:
  - Full: wr_ready=0, wr_valid is ignored, no RAM write occurs.
  - Empty: rd_valid=0, rd_ready is ignored.
  - Pop while mem_cnt=0: out_valid clears and count decrements.
  - Simultaneous wr_valid and a refill need: the read wins and wr_ready=0 for that cycle; the write is accepted the next cycle.
  - Pop together with push: allowed only when rd_issue=0; count is unchanged.

Test Plan:
- Reset: rst_n=0 for 2 cycles with wr_valid=1 -> wr_ready=0, ram_en=0, count=0, empty=1, rd_valid=0, rd_data=0.
- Single word: push 0xA5A5 at edge k with rd_ready=0.
  - Cycle after edge k: ram_en=1, ram_we=0, ram_addr=0.
  - After edge k+2: rd_valid=1, rd_data=0xA5A5, count=1.
  - Pop -> empty=1.
- Fill: rd_ready=0, push 0x0000..0x003F.
  - After the 64th accept: full=1, count=64, wr_ready=0.
  - A further wr_valid produces no ram_en pulse.
  - Head = 0x0000.
- Wrap: fill 64 words, drain 10, push 10 more -> ram_addr issued for writes 0..9 after 63. Drain all -> sequence 10..63 then the new 10 words, in order, with no loss.
- Contention: FIFO holds 3 words, rd_ready=1 and wr_valid=1 continuously.
  - Every cycle with rd_issue=1 has wr_ready=0.
  - Pops occur every 2nd cycle.
  - Output order equals input order.
- Reset mid-stream: 20 words held with a read in flight, rst_n=0 for 1 cycle -> count=0, rd_valid=0. A following push 0x1234 is read back as 0x1234 from ram_addr 0.

Source files
------------

// File: rtl/spram_fifo_ctrl.sv
// Circular-buffer FIFO controller that sits in front of a 64x16 single-port
// write-first RAM. It turns a valid/ready write stream and a valid/ready read
// stream into one RAM access per cycle. Reads take priority over writes.
// Read data is caught in an output register, because a later write-first
// access overwrites the RAM's DO.
module spram_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              inflight;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    logic rd_issue, push, pop;

    // Occupancy counts every word the block owns: those still in the RAM,
    // one read on its way back, and the output register.
    always_comb begin
        count = mem_cnt + (ADDR_W+1)'(inflight) + (ADDR_W+1)'(out_valid);
        full  = (count == DEPTH_C);
        empty = (count == '0);
    end

    // Issue and handshake decisions. Only one read is in flight at a time,
    // and it goes out when the output register is free or is being drained.
    // wr_ready is built from state and rd_ready only, so it never depends
    // on wr_valid.
    always_comb begin
        pop      = out_valid & rd_ready;
        rd_issue = rst_n & (mem_cnt != '0) & ~inflight & (~out_valid | rd_ready);
        wr_ready = rst_n & ~full & ~rd_issue;
        push     = wr_valid & wr_ready;
    end

    // RAM port drive. rd_issue and push never fire together.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = wr_data;
        if (rd_issue) begin
            ram_en   = 1'b1;
            ram_addr = rd_ptr;
        end else if (push) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_ptr;
        end
    end

    // Pointers and the RAM word count. The pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + (ADDR_W+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (ADDR_W+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_issue;
        end
    end

    // Output register. RAM DO is valid for one cycle after a read, so it is
    // captured then. A pop with nothing returning empties the register.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (inflight) begin
            out_valid <= 1'b1;
            out_data  <= ram_do;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    assign rd_valid = out_valid;
    assign rd_data  = out_data;

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl with a behavioural write-first RAM
// attached and a queue that holds the expected read order.
module tb_spram_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready = 1'b0;
    logic [6:0]  count;
    logic        full, empty;
    logic        ram_en, ram_we;
    logic [5:0]  ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_do = '0;

    logic [15:0] mem [64];
    logic [15:0] q [$];
    logic [5:0]  mwp;
    int total = 0;
    int bad   = 0;

    spram_fifo_ctrl #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // 64x16 single-port write-first RAM
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_do        <= ram_di;
            end else begin
                ram_do <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mwp = '0;
        q.delete();
    endtask

    // push one word, checking the RAM write address at accept
    task automatic push_w(input logic [15:0] d);
        bit ok = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (wr_ready) begin ok = 1; break; end
            @(posedge CLK);
            #1;
        end
        if (!ok) begin
            chk("push_timeout", 0, 1);
        end else begin
            chk("wr_addr", {ram_en, ram_we, ram_addr}, {2'b11, mwp});
            mwp++;
            q.push_back(d);
            step();
        end
        wr_valid = 1'b0;
    endtask

    // wait for the head word, check it against the queue, then pop it
    task automatic pop_w();
        bit ok = 0;
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rd_valid) begin ok = 1; break; end
            @(posedge CLK);
            #1;
        end
        if (!ok || q.size() == 0) begin
            chk("pop_timeout", 0, 1);
        end else begin
            e = q.pop_front();
            chk("rd_data", rd_data, e);
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int pops;
        // reset held with a write request present
        rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_data = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_ram_en", ram_en, 0);
        end
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);

        // single word
        rst_n = 1'b1;
        wr_data = 16'hA5A5;
        #1;
        chk("sw_wr_ready", wr_ready, 1);
        chk("sw_wr_port", {ram_en, ram_we, ram_addr}, {2'b11, 6'd0});
        step();
        wr_valid = 1'b0;
        #1;
        chk("sw_rd_port", {ram_en, ram_we, ram_addr}, {2'b10, 6'd0});
        chk("sw_count1", count, 1);
        chk("sw_rv_k1", rd_valid, 0);
        step();
        chk("sw_rv_k2", rd_valid, 0);
        step();
        chk("sw_rv", rd_valid, 1);
        chk("sw_rd", rd_data, 16'hA5A5);
        chk("sw_count", count, 1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("sw_empty", empty, 1);
        chk("sw_rv_after", rd_valid, 0);

        // fill to full
        do_reset();
        for (int i = 0; i < 64; i++) push_w(16'(i));
        chk("fill_count", count, 64);
        chk("fill_full", full, 1);
        chk("fill_wr_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_no_en", ram_en, 0);
            step();
        end
        wr_valid = 1'b0;
        chk("fill_count2", count, 64);
        chk("fill_head", rd_data, 16'h0000);

        // wrap: drain 10, push 10 (addresses 0..9 again), drain all in order
        for (int i = 0; i < 10; i++) pop_w();
        chk("wrap_mwp", mwp, 0);
        for (int i = 0; i < 10; i++) push_w(16'h0100 + 16'(i));
        chk("wrap_full", full, 1);
        for (int i = 0; i < 64; i++) pop_w();
        #1;
        chk("wrap_empty", empty, 1);
        chk("wrap_count", count, 0);

        // contention: 3 words held, continuous read and write demand
        do_reset();
        for (int i = 0; i < 3; i++) push_w(16'h0200 + 16'(i));
        for (int i = 0; i < 3; i++) step();
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h0203;
        last = -1;
        pops = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (ram_en && !ram_we) chk("rd_prio", wr_ready, 0);
            if (rd_valid && q.size() > 0) begin
                chk("cont_data", rd_data, q.pop_front());
                if (last >= 0) chk("pop_gap", c - last, 2);
                last = c;
                pops++;
            end
            if (wr_ready) begin
                chk("cont_wr_addr", {ram_en, ram_we, ram_addr}, {2'b11, mwp});
                mwp++;
                q.push_back(wr_data);
            end
            step();
            if (q.size() > 0 && q[q.size()-1] == wr_data) wr_data = wr_data + 16'd1;
        end
        chk("cont_pops", pops, 12);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        while (q.size() > 0) pop_w();
        #1;
        chk("cont_empty", empty, 1);

        // reset with a read in flight
        do_reset();
        for (int i = 0; i < 20; i++) push_w(16'h0300 + 16'(i));
        for (int i = 0; i < 3; i++) step();
        rd_ready = 1'b1;
        #1;
        chk("mid_issue", {ram_en, ram_we}, 2'b10);
        step();
        rd_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", ram_en, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_count", count, 0);
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_empty", empty, 1);
        mwp = '0;
        q.delete();
        push_w(16'h1234);
        #1;
        chk("mid_rd_port", {ram_en, ram_we, ram_addr}, {2'b10, 6'd0});
        pop_w();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
